// File: rtl/pixel_buffer_writer.sv
// pixel_buffer_writer: packs 2-bit pixels four per byte into the frame buffer, coalescing same-byte pixels.
// Full bytes are written blind and partial bytes go read-modify-write. Build macro PIXEL_FB_CLEAR_EN adds a full-frame clear.
//
// state   | meaning
// S_IDLE  | waiting; pops the FIFO head (or starts a clear when enabled)
// S_READ  | fb_addr driven with fb_we=0 to fetch the old byte
// S_MERGE | fb_rdata valid; merge the masked pixels into it
// S_WRITE | fb_we=1 for one cycle
// S_CLEAR | writes 0x00 to every byte, one per cycle
module pixel_buffer_writer #(
    parameter int FB_W       = 160,
    parameter int FB_H       = 120,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              draw,
    input  logic [7:0]        x_in,
    input  logic [7:0]        y_in,
    input  logic [1:0]        color,
    input  logic [7:0]        fb_rdata,
    output logic [ADDR_W-1:0] fb_addr,
    output logic              fb_we,
    output logic [7:0]        fb_wdata,
    output logic              busy,
    output logic              overflow,
    input  logic              clear,
    output logic              clear_done
);

    localparam int BPR      = FB_W / 4;
    localparam int FB_BYTES = BPR * FB_H;
    localparam int PTR_W    = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
        logic [3:0]        mask;
    } entry_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_MERGE = 3'd2,
        S_WRITE = 3'd3,
        S_CLEAR = 3'd4
    } state_t;

    // Mask bit i covers slot i; slot 0 sits in the MSBs.
    function automatic logic [7:0] expand(input logic [3:0] m);
        return {{2{m[0]}}, {2{m[1]}}, {2{m[2]}}, {2{m[3]}}};
    endfunction

    logic              w_acc;
    logic [ADDR_W-1:0] w_pix_addr;
    logic [3:0]        w_pix_mask;
    logic [7:0]        w_pix_data;
    logic              w_push;
    logic              w_pop;
    logic              w_wr;
    logic              w_empty;
    logic              w_full;
    logic [7:0]        w_merged;
    entry_t            w_head;

    logic              r_pend_v;
    logic [ADDR_W-1:0] r_pend_addr;
    logic [7:0]        r_pend_data;
    logic [3:0]        r_pend_mask;

    entry_t            r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;

    state_t            r_state;
    logic [7:0]        r_cur_data;
    logic [3:0]        r_cur_mask;

    assign w_acc      = draw && (int'(x_in) < FB_W) && (int'(y_in) < FB_H);
    assign w_pix_addr = ADDR_W'(y_in) * ADDR_W'(BPR) + ADDR_W'(x_in[7:2]);
    assign w_pix_mask = 4'b0001 << x_in[1:0];
    assign w_pix_data = {color, 6'b0} >> {x_in[1:0], 1'b0};

    // A full pending byte leaves on the cycle after it fills, even if the same byte is hit again.
    assign w_push = r_pend_v && (!w_acc || (r_pend_mask == 4'hF) || (w_pix_addr != r_pend_addr));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend_v    <= 1'b0;
            r_pend_addr <= '0;
            r_pend_data <= '0;
            r_pend_mask <= '0;
        end else if (w_acc && r_pend_v && !w_push) begin
            r_pend_data <= (r_pend_data & ~expand(w_pix_mask)) | w_pix_data;
            r_pend_mask <= r_pend_mask | w_pix_mask;
        end else if (w_acc) begin
            r_pend_v    <= 1'b1;
            r_pend_addr <= w_pix_addr;
            r_pend_data <= w_pix_data;
            r_pend_mask <= w_pix_mask;
        end else if (w_push) begin
            r_pend_v    <= 1'b0;
        end
    end

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == (PTR_W+1)'(FIFO_DEPTH));
    assign w_pop   = (r_state == S_IDLE) && !w_empty;
    assign w_wr    = w_push && (!w_full || w_pop);
    assign w_head  = r_fifo[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_fifo[r_wr_ptr] <= {r_pend_addr, r_pend_data, r_pend_mask};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push && !w_wr) begin
                overflow <= 1'b1;
            end
        end
    end

    assign w_merged = (fb_rdata & ~expand(r_cur_mask)) | (r_cur_data & expand(r_cur_mask));
    assign busy     = r_pend_v || !w_empty || (r_state != S_IDLE);

`ifdef PIXEL_FB_CLEAR_EN
    logic r_clr_req;
`else
    logic w_unused_clear;
    assign w_unused_clear = clear;
    assign clear_done     = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cur_data <= '0;
            r_cur_mask <= '0;
            fb_addr    <= '0;
            fb_we      <= 1'b0;
            fb_wdata   <= '0;
`ifdef PIXEL_FB_CLEAR_EN
            r_clr_req  <= 1'b0;
            clear_done <= 1'b0;
`endif
        end else begin
            fb_we <= 1'b0;
`ifdef PIXEL_FB_CLEAR_EN
            clear_done <= 1'b0;
            if (clear && (r_state != S_CLEAR)) begin
                r_clr_req <= 1'b1;
            end
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_cur_data <= w_head.data;
                        r_cur_mask <= w_head.mask;
                        fb_addr    <= w_head.addr;
                        if (w_head.mask == 4'hF) begin
                            fb_we    <= 1'b1;
                            fb_wdata <= w_head.data;
                            r_state  <= S_WRITE;
                        end else begin
                            r_state  <= S_READ;
                        end
                    end
`ifdef PIXEL_FB_CLEAR_EN
                    else if (r_clr_req) begin
                        r_clr_req <= 1'b0;
                        fb_we     <= 1'b1;
                        fb_addr   <= '0;
                        fb_wdata  <= 8'h00;
                        r_state   <= S_CLEAR;
                    end
`endif
                end
                S_READ: begin
                    r_state <= S_MERGE;
                end
                S_MERGE: begin
                    fb_we    <= 1'b1;
                    fb_wdata <= w_merged;
                    r_state  <= S_WRITE;
                end
                S_WRITE: begin
                    r_state <= S_IDLE;
                end
`ifdef PIXEL_FB_CLEAR_EN
                S_CLEAR: begin
                    if (fb_addr == ADDR_W'(FB_BYTES - 1)) begin
                        clear_done <= 1'b1;
                        r_state    <= S_IDLE;
                    end else begin
                        fb_we   <= 1'b1;
                        fb_addr <= fb_addr + 1'b1;
                    end
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_buffer_writer.sv
// Bench for pixel_buffer_writer: directed steps with a write scoreboard and a registered-read frame buffer model.
// Instance A uses default parameters; instance B uses FIFO_DEPTH=2 for the overflow case.
module tb_pixel_buffer_writer;

    typedef struct {
        logic [12:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic        draw_a, draw_b, clear_a, clear_b;
    logic [7:0]  x_a, y_a, x_b, y_b;
    logic [1:0]  c_a, c_b;
    logic [7:0]  rdata_a = 8'h00, rdata_b = 8'h00;
    logic [12:0] addr_a, addr_b;
    logic        we_a, we_b, busy_a, busy_b, ovf_a, ovf_b, done_a, done_b;
    logic [7:0]  wdata_a, wdata_b;

    bit   [7:0]  val_a [0:4799];
    bit          flag_a [0:4799];
    bit   [7:0]  val_b [0:4799];
    bit          flag_b [0:4799];

    wr_t         qa[$];
    wr_t         qb[$];
    int          n_assert = 0;
    int          n_fail = 0;
    int          rd_cnt_a = 0;
    int          done_cnt_a = 0;
    logic [12:0] prev_a = '0;

    always #5 clk = ~clk;

    pixel_buffer_writer u_a (
        .clk(clk), .reset(rst_a), .draw(draw_a), .x_in(x_a), .y_in(y_a), .color(c_a),
        .fb_rdata(rdata_a), .fb_addr(addr_a), .fb_we(we_a), .fb_wdata(wdata_a),
        .busy(busy_a), .overflow(ovf_a), .clear(clear_a), .clear_done(done_a)
    );

    pixel_buffer_writer #(.FIFO_DEPTH(2)) u_b (
        .clk(clk), .reset(rst_b), .draw(draw_b), .x_in(x_b), .y_in(y_b), .color(c_b),
        .fb_rdata(rdata_b), .fb_addr(addr_b), .fb_we(we_b), .fb_wdata(wdata_b),
        .busy(busy_b), .overflow(ovf_b), .clear(clear_b), .clear_done(done_b)
    );

    function automatic logic [7:0] base(input logic [12:0] a);
        return (a == 13'd41) ? 8'h81 : 8'h15;
    endfunction

    // Frame buffer model: read data appears one cycle after the address.
    always @(posedge clk) begin
        if (we_a && addr_a < 13'd4800) begin
            val_a[addr_a]  <= wdata_a;
            flag_a[addr_a] <= 1'b1;
        end
        rdata_a <= (addr_a < 13'd4800) ? (flag_a[addr_a] ? val_a[addr_a] : base(addr_a)) : 8'h00;
        if (we_b && addr_b < 13'd4800) begin
            val_b[addr_b]  <= wdata_b;
            flag_b[addr_b] <= 1'b1;
        end
        rdata_b <= (addr_b < 13'd4800) ? (flag_b[addr_b] ? val_b[addr_b] : base(addr_b)) : 8'h00;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_a) begin
            if (we_a) begin
                if (qa.size() == 0) begin
                    check("unexpected_wr_a", 32'(we_a), 32'd0);
                end else begin
                    wr_t e;
                    e = qa.pop_front();
                    check("wr_addr_a", 32'(addr_a), 32'(e.addr));
                    check("wr_data_a", 32'(wdata_a), 32'(e.data));
                end
            end else if (addr_a != prev_a) begin
                rd_cnt_a++;
            end
            if (done_a) done_cnt_a++;
        end
        prev_a = addr_a;
    end

    always @(negedge clk) begin
        if (rst_b && we_b) begin
            if (qb.size() == 0) begin
                check("unexpected_wr_b", 32'(we_b), 32'd0);
            end else begin
                wr_t e;
                e = qb.pop_front();
                check("wr_addr_b", 32'(addr_b), 32'(e.addr));
                check("wr_data_b", 32'(wdata_b), 32'(e.data));
            end
        end
    end

    task automatic pix_a(input logic d, input logic [7:0] x, input logic [7:0] y, input logic [1:0] c);
        draw_a = d; x_a = x; y_a = y; c_a = c;
        @(posedge clk); #1;
        draw_a = 1'b0;
    endtask

    task automatic pix_b(input logic d, input logic [7:0] x, input logic [7:0] y, input logic [1:0] c);
        draw_b = d; x_b = x; y_b = y; c_b = c;
        @(posedge clk); #1;
        draw_b = 1'b0;
    endtask

    task automatic drain_a(input int limit);
        int n = 0;
        while ((busy_a || qa.size() != 0) && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_a_in_time", 32'(n < limit), 32'd1);
    endtask

    task automatic drain_b(input int limit);
        int n = 0;
        while ((busy_b || qb.size() != 0) && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_b_in_time", 32'(n < limit), 32'd1);
    endtask

    function automatic wr_t mk(input logic [12:0] a, input logic [7:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        return w;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] cs [8];
        int         keep [5];
        int         rd0;
        int         n;
        cs   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
        keep = '{0, 1, 2, 5, 9};

        rst_a = 1'b0; rst_b = 1'b0;
        draw_a = 1'b0; draw_b = 1'b0; clear_a = 1'b0; clear_b = 1'b0;
        x_a = '0; y_a = '0; c_a = '0; x_b = '0; y_b = '0; c_b = '0;

        // Reset state
        @(negedge clk);
        check("rst_addr", 32'(addr_a), 32'd0);
        check("rst_we", 32'(we_a), 32'd0);
        check("rst_wdata", 32'(wdata_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_ovf", 32'(ovf_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        @(posedge clk); #1;
        rst_a = 1'b1; rst_b = 1'b1;
        @(posedge clk); #1;

        // Two full bytes from eight consecutive pixels: blind writes, no reads
        rd0 = rd_cnt_a;
        qa.push_back(mk(13'd2, 8'h1B));
        qa.push_back(mk(13'd3, 8'hE4));
        for (int i = 0; i < 8; i++) pix_a(1'b1, 8'(8 + i), 8'd0, cs[i]);
        drain_a(50);
        check("full_no_reads", 32'(rd_cnt_a - rd0), 32'd0);

        // Single pixel read-modify-write over 0x81
        rd0 = rd_cnt_a;
        qa.push_back(mk(13'd41, 8'hB1));
        pix_a(1'b1, 8'd5, 8'd1, 2'd3);
        drain_a(50);
        check("partial_one_read", 32'(rd_cnt_a - rd0), 32'd1);
        check("ovf_a_clear", 32'(ovf_a), 32'd0);

        // Out-of-range pixels are ignored
        pix_a(1'b1, 8'd160, 8'd0, 2'd1);
        check("oor_x_busy", 32'(busy_a), 32'd0);
        pix_a(1'b1, 8'd0, 8'd120, 2'd2);
        check("oor_y_busy", 32'(busy_a), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("oor_busy_idle", 32'(busy_a), 32'd0);
        end

        // Depth-2 FIFO overrun: only entries 0,1,2,5,9 survive
        for (int i = 0; i < 5; i++)
            qb.push_back(mk(13'(keep[i]), 8'h15 | {2'(keep[i] + 1), 6'b0}));
        for (int k = 0; k < 12; k++) pix_b(1'b1, 8'(4 * k), 8'd0, 2'(k + 1));
        drain_b(200);
        check("ovf_b_set", 32'(ovf_b), 32'd1);
        check("ovf_b_queue_empty", 32'(qb.size()), 32'd0);

        // Reset during MERGE aborts the entry
        pix_a(1'b1, 8'd100, 8'd50, 2'd1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(addr_a == 13'd2025 && !we_a) && n < 50);
        check("read_cycle_seen", 32'(n < 50), 32'd1);
        @(posedge clk); #1;
        rst_a = 1'b0;
        @(negedge clk);
        check("abort_addr", 32'(addr_a), 32'd0);
        check("abort_we", 32'(we_a), 32'd0);
        check("abort_wdata", 32'(wdata_a), 32'd0);
        check("abort_busy", 32'(busy_a), 32'd0);
        check("abort_ovf", 32'(ovf_a), 32'd0);
        @(posedge clk); #1;
        rst_a = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
        end
        check("abort_busy_after", 32'(busy_a), 32'd0);

`ifdef PIXEL_FB_CLEAR_EN
        // Clear writes 4800 zeros; a pixel sent mid-clear follows it
        n = done_cnt_a;
        for (int i = 0; i < 4800; i++) qa.push_back(mk(13'(i), 8'h00));
        qa.push_back(mk(13'd0, 8'h80));
        clear_a = 1'b1;
        @(posedge clk); #1;
        clear_a = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
        end
        clear_a = 1'b1;
        pix_a(1'b1, 8'd0, 8'd0, 2'd2);
        clear_a = 1'b0;
        drain_a(6000);
        check("clear_done_once", 32'(done_cnt_a - n), 32'd1);
`else
        // Without the clear feature the request does nothing
        n = done_cnt_a;
        clear_a = 1'b1;
        @(posedge clk); #1;
        clear_a = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
        end
        check("no_clear_done", 32'(done_cnt_a - n), 32'd0);
        check("no_clear_busy", 32'(busy_a), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
